// File: rtl/rc4_pkg.sv
// rc4_pkg: state encoding, watchdog limit and requester indices shared by the
// RC4 frame scheduler and its arbiter.
package rc4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARB    = 3'd1,
        ST_KEY    = 3'd2,
        ST_KSA    = 3'd3,
        ST_STREAM = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    localparam int   KSA_TIMEOUT = 1023;
    localparam logic REQ_ENC     = 1'b0;
    localparam logic REQ_DEC     = 1'b1;

    function automatic logic [1:0] idx_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rc4_sched_if.sv
// rc4_sched_if: requester-side bus of the scheduler (requests, grants, byte
// stream in, result stream out). master = requesters, slave = scheduler.
interface rc4_sched_if #(
    parameter int FRAME_W = 8
) ();

    logic [1:0]         req;
    logic [FRAME_W-1:0] len_m1_0;
    logic [FRAME_W-1:0] len_m1_1;
    logic [1:0]         gnt;
    logic               s_valid;
    logic [7:0]         s_data;
    logic               s_ready;
    logic               m_valid;
    logic [7:0]         m_data;
    logic               m_sel;
    logic               frame_done;
    logic               err;

    modport master (
        output req, len_m1_0, len_m1_1, s_valid, s_data,
        input  gnt, s_ready, m_valid, m_data, m_sel, frame_done, err
    );

    modport slave (
        input  req, len_m1_0, len_m1_1, s_valid, s_data,
        output gnt, s_ready, m_valid, m_data, m_sel, frame_done, err
    );

endinterface

// File: rtl/rc4_rr_arb.sv
// rc4_rr_arb: two-way round-robin arbiter; the pointer names the requester
// that wins a tie and moves away from the served one on each done strobe.
module rc4_rr_arb
    import rc4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       done,
    input  logic       served,
    output logic       winner
);

    logic ptr_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg <= REQ_ENC;
        end else if (done) begin
            ptr_reg <= ~served;
        end
    end

    always_comb begin
        winner = ptr_reg;
        if (req == 2'b01) begin
            winner = REQ_ENC;
        end else if (req == 2'b10) begin
            winner = REQ_DEC;
        end
    end

endmodule

// File: rtl/rc4_sched.sv
// rc4_sched: shares one RC4 core between encrypt/decrypt requesters, one frame
// at a time. Define RC4_SCHED_KSA_TIMEOUT_EN to enable the KSA watchdog.
module rc4_sched
    import rc4_pkg::*;
#(
    parameter int KEY_LEN  = 16,
    parameter int FRAME_W  = 8,
    parameter int CORE_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    rc4_sched_if.slave bus,
    output logic [7:0] key_addr,
    input  logic [7:0] key_byte,
    output logic [7:0] core_password,
    output logic       core_key_valid,
    output logic       core_restart,
    input  logic       core_init_done,
    output logic       core_valid,
    output logic [7:0] core_data_in,
    input  logic [7:0] core_data_out
);

    localparam int         CNT_W    = FRAME_W + 1;
    localparam logic [7:0] KEY_LAST = 8'(KEY_LEN - 1);
    localparam logic [1:0] LAT_LAST = 2'(CORE_LAT - 1);

    state_t             state_reg, state_next;
    logic               sel_reg;
    logic [CNT_W-1:0]   len_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [7:0]         key_cnt_reg;
    logic [1:0]         lat_cnt_reg;
    logic [CNT_W-1:0]   cnt_inc;
    logic [FRAME_W-1:0] len_m1_sel;
    logic               arb_winner;
    logic               accept;
    logic               ksa_timeout;
    logic               frame_ok;
    logic               in_frame;
    logic [CORE_LAT:0]  mv_chain;

    rc4_rr_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req),
        .done   (state_reg == ST_DONE),
        .served (sel_reg),
        .winner (arb_winner)
    );

    assign cnt_inc    = cnt_reg + CNT_W'(1);
    assign len_m1_sel = sel_reg ? bus.len_m1_1 : bus.len_m1_0;
    assign accept     = (state_reg == ST_STREAM) && (cnt_reg < len_reg) && bus.s_valid;

`ifdef RC4_SCHED_KSA_TIMEOUT_EN
    logic [9:0] wd_reg;
    logic       abort_reg;

    assign ksa_timeout = (state_reg == ST_KSA) && !core_init_done
                         && (wd_reg == 10'(KSA_TIMEOUT - 1));
    assign frame_ok    = !abort_reg;

    // Watchdog runs only while waiting in KSA; abort suppresses frame_done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_reg    <= '0;
            abort_reg <= 1'b0;
        end else begin
            wd_reg <= (state_reg == ST_KSA) ? wd_reg + 10'd1 : 10'd0;
            if (state_reg == ST_ARB) begin
                abort_reg <= 1'b0;
            end else if (ksa_timeout) begin
                abort_reg <= 1'b1;
            end
        end
    end
`else
    assign ksa_timeout = 1'b0;
    assign frame_ok    = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (|bus.req) state_next = ST_ARB;
            ST_ARB:    state_next = ST_KEY;
            ST_KEY:    if (key_cnt_reg == KEY_LAST) state_next = ST_KSA;
            ST_KSA: begin
                if (ksa_timeout) begin
                    state_next = ST_DONE;
                end else if (core_init_done) begin
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: if (accept && (cnt_inc == len_reg)) state_next = ST_DRAIN;
            ST_DRAIN:  if (lat_cnt_reg == LAT_LAST) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Owner is chosen on leaving IDLE; length is captured one cycle later in ARB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_reg     <= 1'b0;
            len_reg     <= '0;
            cnt_reg     <= '0;
            key_cnt_reg <= '0;
            lat_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: if (|bus.req) sel_reg <= arb_winner;
                ST_ARB: begin
                    len_reg     <= {1'b0, len_m1_sel} + CNT_W'(1);
                    cnt_reg     <= '0;
                    key_cnt_reg <= '0;
                end
                ST_KEY: key_cnt_reg <= key_cnt_reg + 8'd1;
                ST_STREAM: begin
                    lat_cnt_reg <= '0;
                    if (accept) cnt_reg <= cnt_inc;
                end
                ST_DRAIN: lat_cnt_reg <= lat_cnt_reg + 2'd1;
                default: ;
            endcase
        end
    end

    assign mv_chain[0] = core_valid;

    for (genvar gi = 0; gi < CORE_LAT; gi++) begin : g_lat
        logic stage_reg;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                stage_reg <= 1'b0;
            end else begin
                stage_reg <= mv_chain[gi];
            end
        end
        assign mv_chain[gi+1] = stage_reg;
    end

    always_comb begin
        in_frame       = (state_reg == ST_ARB) || (state_reg == ST_KEY) || (state_reg == ST_KSA)
                         || (state_reg == ST_STREAM) || (state_reg == ST_DRAIN);
        bus.gnt        = in_frame ? idx_onehot(sel_reg) : 2'b00;
        bus.s_ready    = (state_reg == ST_STREAM) && (cnt_reg < len_reg);
        bus.m_valid    = mv_chain[CORE_LAT];
        bus.m_data     = mv_chain[CORE_LAT] ? core_data_out : 8'h00;
        bus.m_sel      = sel_reg;
        bus.frame_done = (state_reg == ST_DONE) && frame_ok;
        bus.err        = ksa_timeout;
        key_addr       = (state_reg == ST_KEY) ? key_cnt_reg : 8'h00;
        core_password  = (state_reg == ST_KEY) ? key_byte : 8'h00;
        core_key_valid = (state_reg == ST_KEY);
        core_restart   = (state_reg == ST_ARB) || ksa_timeout;
        core_valid     = accept;
        core_data_in   = accept ? bus.s_data : 8'h00;
    end

endmodule

// File: tb/tb_rc4_sched.sv
// tb_rc4_sched: scoreboard bench for rc4_sched with a behavioural RC4 core
// stand-in (XOR keystream, 1-cycle latency) and a combinational key ROM.
module tb_rc4_sched;
    import rc4_pkg::*;

    localparam int KEY_LEN  = 16;
    localparam int FRAME_W  = 8;
    localparam int CORE_LAT = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] key_addr, key_byte, core_password, core_data_in, core_data_out;
    logic       core_key_valid, core_restart, core_valid;
    logic       init_done = 1'b0;
    bit         init_en = 1'b1;

    rc4_sched_if #(.FRAME_W(FRAME_W)) bus ();

    rc4_sched #(.KEY_LEN(KEY_LEN), .FRAME_W(FRAME_W), .CORE_LAT(CORE_LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .key_addr       (key_addr),
        .key_byte       (key_byte),
        .core_password  (core_password),
        .core_key_valid (core_key_valid),
        .core_restart   (core_restart),
        .core_init_done (init_done),
        .core_valid     (core_valid),
        .core_data_in   (core_data_in),
        .core_data_out  (core_data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] kfn(input logic [7:0] a);
        return a * 8'd7 + 8'h3C;
    endfunction

    assign key_byte = kfn(key_addr);

    // Core stand-in: result = data ^ 5A one cycle later; init_done 5 cycles after the keys.
    logic [7:0] core_q = 8'h00;
    int         kstb = 0;
    int         dly = 0;
    assign core_data_out = core_q;

    always @(posedge clk) begin
        core_q <= core_data_in ^ 8'h5A;
        if (core_restart) begin
            kstb      <= 0;
            dly       <= 0;
            init_done <= 1'b0;
        end else if (core_key_valid) begin
            kstb <= kstb + 1;
        end else if (init_en && kstb == KEY_LEN && !init_done) begin
            if (dly == 4) init_done <= 1'b1;
            else          dly <= dly + 1;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    int         cyc = 0, gnt_rise = 0, ks_n = 0, exp_ka = 0;
    int         acc_n = 0, mv_n = 0, fd_n = 0, err_n = 0, last_acc = 0, last_mv = 0;
    logic [1:0] prev_gnt = 2'b00;
    logic [8:0] sbq[$];
    int         acq[$];

    always @(negedge clk) begin
        if (rst) begin
            cyc++;
            if (bus.gnt != 2'b00) chk("gnt_1hot", 32'(bus.gnt == 2'b11), 0);
            if (bus.gnt != 2'b00 && prev_gnt == 2'b00) gnt_rise = cyc;
            if (core_restart) begin
                exp_ka = 0;
                ks_n   = 0;
            end
            if (core_key_valid) begin
                if (ks_n == 0) chk("key_lat", cyc - gnt_rise, 1);
                chk("key_addr", key_addr, exp_ka);
                chk("key_pw", core_password, kfn(8'(exp_ka)));
                exp_ka++;
                ks_n++;
            end
            if (bus.s_valid && bus.s_ready) begin
                chk("core_in", {core_valid, core_data_in}, {1'b1, bus.s_data});
                sbq.push_back({bus.gnt[1], bus.s_data ^ 8'h5A});
                acq.push_back(cyc);
                acc_n++;
                last_acc = cyc;
            end else if (core_valid) begin
                chk("core_valid_spur", core_valid, 0);
            end
            if (bus.m_valid) begin
                if (sbq.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    chk("result", {bus.m_sel, bus.m_data}, sbq.pop_front());
                    chk("m_lat", cyc - acq.pop_front(), CORE_LAT);
                end
                mv_n++;
                last_mv = cyc;
            end
            if (bus.frame_done) begin
                fd_n++;
                chk("fd_after_acc", cyc - last_acc, CORE_LAT + 1);
                chk("fd_after_mv", cyc - last_mv, 1);
            end
            if (bus.err) err_n++;
            prev_gnt = bus.gnt;
        end
    end

    task automatic check_quiet(input string tag);
        chk({tag, "_gnt"}, bus.gnt, 0);
        chk({tag, "_sready"}, bus.s_ready, 0);
        chk({tag, "_mvalid"}, bus.m_valid, 0);
        chk({tag, "_mdata"}, bus.m_data, 0);
        chk({tag, "_msel"}, bus.m_sel, 0);
        chk({tag, "_fd"}, bus.frame_done, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_kv"}, core_key_valid, 0);
        chk({tag, "_kaddr"}, key_addr, 0);
        chk({tag, "_pw"}, core_password, 0);
        chk({tag, "_restart"}, core_restart, 0);
        chk({tag, "_cvalid"}, core_valid, 0);
        chk({tag, "_cdata"}, core_data_in, 0);
    endtask

    task automatic wait_gnt(input logic [1:0] want, input string tag, output int w);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (bus.gnt == 2'b00 && w < 400);
        chk(tag, bus.gnt, want);
    endtask

    task automatic stream_bytes(input int n, input bit toggle, input string tag);
        int sent = 0;
        int guard = 0;
        bit ph = 1'b0;
        while (sent < n && guard < 4 * n + 300) begin
            @(posedge clk);
            #1;
            ph = ~ph;
            bus.s_valid = toggle ? ph : 1'b1;
            bus.s_data  = 8'($urandom);
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) sent++;
            guard++;
        end
        @(posedge clk);
        #1 bus.s_valid = 1'b0;
        chk({tag, "_sent"}, sent, n);
    endtask

    task automatic wait_fd(input string tag);
        int w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.frame_done && w < 50);
        chk({tag, "_fd_seen"}, bus.frame_done, 1);
    endtask

    // Expects req/len already driven; drops the granted req and corrupts its length after grant.
    task automatic serve(input logic idx, input int len_m1, input bit toggle,
                         input string tag, output int w);
        int         a0, m0, f0;
        logic [1:0] want;
        want = idx_onehot(idx);
        a0 = acc_n;
        m0 = mv_n;
        f0 = fd_n;
        wait_gnt(want, {tag, "_gnt"}, w);
        @(posedge clk);
        #1;
        bus.req[idx] = 1'b0;
        if (idx) bus.len_m1_1 = ~bus.len_m1_1;
        else     bus.len_m1_0 = ~bus.len_m1_0;
        stream_bytes(len_m1 + 1, toggle, tag);
        wait_fd(tag);
        @(negedge clk);
        chk({tag, "_acc"}, acc_n - a0, len_m1 + 1);
        chk({tag, "_mv"}, mv_n - m0, len_m1 + 1);
        chk({tag, "_fd"}, fd_n - f0, 1);
        chk({tag, "_keys"}, ks_n, KEY_LEN);
        chk({tag, "_sbq"}, sbq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: sim time expired");
        $fatal(1, "global timeout");
    end

    initial begin
        int w, sr, e0, f0;
        bus.req      = 2'b00;
        bus.len_m1_0 = '0;
        bus.len_m1_1 = '0;
        bus.s_valid  = 1'b0;
        bus.s_data   = 8'h00;

        #2 rst = 1'b0;
        #3 check_quiet("rst");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Contention: 0 first after reset, then 1, then 0 again.
        @(posedge clk);
        #1;
        bus.len_m1_0 = 8'd2;
        bus.len_m1_1 = 8'd4;
        bus.req      = 2'b11;
        serve(REQ_ENC, 2, 1'b0, "cont_a", w);
        serve(REQ_DEC, 4, 1'b0, "cont_b", w);
        @(posedge clk);
        #1;
        bus.len_m1_0 = 8'd1;
        bus.len_m1_1 = 8'd1;
        bus.req      = 2'b11;
        serve(REQ_ENC, 1, 1'b0, "cont_c", w);
        serve(REQ_DEC, 1, 1'b0, "cont_d", w);

        // Single frame, grant latency from an idle scheduler.
        @(posedge clk);
        #1;
        bus.len_m1_0 = 8'd3;
        bus.req      = 2'b01;
        serve(REQ_ENC, 3, 1'b0, "single", w);
        chk("single_gnt_lat", w, 2);

        // Backpressure: s_valid toggling.
        @(posedge clk);
        #1;
        bus.len_m1_1 = 8'd7;
        bus.req      = 2'b10;
        serve(REQ_DEC, 7, 1'b1, "bp", w);

        // Maximum frame length.
        @(posedge clk);
        #1;
        bus.len_m1_0 = 8'd255;
        bus.req      = 2'b01;
        serve(REQ_ENC, 255, 1'b0, "max", w);

        // Reset mid-STREAM after 2 of 6 bytes.
        @(posedge clk);
        #1;
        bus.len_m1_1 = 8'd5;
        bus.req      = 2'b10;
        wait_gnt(2'b10, "mid_gnt", w);
        @(posedge clk);
        #1 bus.req = 2'b00;
        stream_bytes(2, 1'b0, "mid");
        @(posedge clk);
        #1 rst = 1'b0;
        #2 check_quiet("mid_rst");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        sbq.delete();
        acq.delete();
        f0 = fd_n;
        repeat (10) @(negedge clk);
        chk("mid_no_fd", fd_n - f0, 0);
        @(posedge clk);
        #1;
        bus.len_m1_1 = 8'd3;
        bus.req      = 2'b10;
        serve(REQ_DEC, 3, 1'b0, "post_rst", w);

        // core_init_done never rises.
        init_en = 1'b0;
        @(posedge clk);
        #1;
        bus.len_m1_0 = 8'd1;
        bus.req      = 2'b01;
        wait_gnt(2'b01, "stk_gnt", w);
        @(posedge clk);
        #1;
        bus.req     = 2'b00;
        bus.s_valid = 1'b1;
        sr = 0;
        e0 = err_n;
        f0 = fd_n;
        repeat (1100) begin
            @(negedge clk);
            if (bus.s_ready) sr++;
        end
        chk("stk_sready", sr, 0);
        chk("stk_no_fd", fd_n - f0, 0);
`ifdef RC4_SCHED_KSA_TIMEOUT_EN
        chk("stk_err", err_n - e0, 1);
        chk("stk_gnt_drop", bus.gnt, 0);
`else
        chk("stk_err", err_n - e0, 0);
        chk("stk_gnt_hold", bus.gnt, 2'b01);
`endif
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        rst         = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        init_en = 1'b1;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
